tile_merge_engine: RTL and testbench
====================================

TILE_MERGE_ENGINE -- requirements
Module: tile_merge_engine

Interface
REQ-001 Parameter N, default 4: board dimension (N x N tiles), N >= 2.
REQ-002 Parameter W, default 12: tile value width in bits; 0 = empty tile.
REQ-003 Parameter WIN_VALUE, default 2048: tile value that raises win.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request one move; sampled only in IDLE.
REQ-007 direction  input  4  one-hot move direction: 1000 left, 0100 down, 0010 up, 0001 right.
REQ-008 matrix  input  [W-1:0] x [N-1:0][N-1:0]  board to move; row index N-1 is the top row.
REQ-009 busy  output  1  high while a move is in progress, including the DONE cycle.
REQ-010 done  output  1  single-cycle pulse when the result is valid.
REQ-011 summed_matrix  output  [W-1:0] x [N-1:0][N-1:0]  board after the move; compaction and merges are both complete.
REQ-012 moved  output  1  at least one tile changed position or value.
REQ-013 win  output  1  at least one merge produced WIN_VALUE.
REQ-014 score  output  W+clog2(N*N)  sum of all merge results in this move.

Function
REQ-015 FSM states: IDLE, PROC, DONE.
REQ-016 IDLE to PROC on start=1: snapshot matrix and direction, clear the line counter, score, moved and win.
REQ-017 PROC handles one line per cycle, lines 0..N-1 in order.
REQ-018 Line mapping: down = column j read from row 0 upward; up = column j from row N-1 downward; left = row i from column 0 rightward; right = row i from column N-1 leftward.
REQ-019 Each line is compacted toward element 0, with zeros removed and order preserved.
REQ-020 Merge pass runs from element 0 upward: two equal adjacent nonzero tiles combine into one tile of double value at the lower index.
REQ-021 Each tile merges at most once per move; the line is then compacted again.
REQ-022 A pair whose value has its MSB set does not merge, which prevents overflow.
REQ-023 The processed line is written back to the same board positions it was read from.
REQ-024 score accumulates each merge result; moved is set when the written line differs from the read line; win is set when a merge result equals WIN_VALUE.
REQ-025 After line N-1 the FSM enters DONE for exactly one cycle with done=1, then returns to IDLE.
REQ-026 Latency: start at cycle 0, done at cycle N+1; busy is high in cycles 1 through N+1.
REQ-027 summed_matrix, score, moved and win hold their values from the done cycle until the next accepted start.
REQ-028 start while busy is ignored; matrix and direction changes during PROC have no effect.
REQ-029 A direction that is not one-hot, including 0000, gives summed_matrix equal to the snapshot, moved=0, score=0, win=0, with normal done timing.
REQ-030 start and rst high in the same cycle: reset wins.

Reset
REQ-031 rst forces state IDLE, busy=0, done=0, moved=0, win=0, score=0, summed_matrix all zero, and line counter 0.
REQ-032 rst during PROC aborts the move and produces no done pulse.

Structure
REQ-033 Shared package game_pkg holds the direction one-hot constants, the FSM state enum and the default N and W.
REQ-034 The per-line compact, merge and compact logic is combinational sub-module line_merge, parametrised by N and W.
REQ-035 line_merge outputs the new line, the line score, a line-changed flag and a win-hit flag.

Verification
REQ-036 Directed: line 2,2,2,2 with direction down -> 4,4,0,0, score 8, moved=1; done pulse at cycle N+1 = 5.
REQ-037 Directed: row 2,0,2,4 with direction left -> 4,4,0,0, score 4; the new 4 must not merge with the existing 4.
REQ-038 Directed: board with no equal neighbours, already packed to the right, direction right -> unchanged, moved=0, score=0.
REQ-039 Directed: two 1024 tiles adjacent, direction up -> one 2048 tile, win=1, score 2048; with W=12, two 2048 tiles do not merge.
REQ-040 Directed: direction 0011 -> board unchanged, done still pulses; start during busy -> ignored, exactly one done pulse.
REQ-041 Directed: rst asserted in cycle 2 of PROC -> no done pulse, all outputs zero the next cycle, a following start is processed normally.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the tile merge engine: default board geometry,
// one-hot move directions and the controller state encoding.
package game_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 12;

    localparam logic [3:0] DIR_LEFT  = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Only the four legal one-hot codes select a move; anything else is a no-op move.
    function automatic logic dir_valid(input logic [3:0] d);
        return (d == DIR_LEFT) || (d == DIR_DOWN) || (d == DIR_UP) || (d == DIR_RIGHT);
    endfunction

endpackage

// File: rtl/tile_merge_engine_if.sv
// Request/result bundle of the tile merge engine. The requester drives the
// move request (master); the engine returns the processed board (slave).
interface tile_merge_engine_if
    import game_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
);
    logic                          start;
    logic [3:0]                    direction;
    logic [N-1:0][N-1:0][W-1:0]    matrix;
    logic                          busy;
    logic                          done;
    logic [N-1:0][N-1:0][W-1:0]    summed_matrix;
    logic                          moved;
    logic                          win;
    logic [W+$clog2(N*N)-1:0]      score;

    modport master (
        output start, direction, matrix,
        input  busy, done, summed_matrix, moved, win, score
    );

    modport slave (
        input  start, direction, matrix,
        output busy, done, summed_matrix, moved, win, score
    );
endinterface

// File: rtl/tile_merge_engine_line_merge.sv
// Combinational single-line move: compact toward element 0, merge equal
// neighbours once from element 0 upward, and emit the compacted result.
module line_merge
    import game_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int W         = DEF_W,
    parameter int WIN_VALUE = 2048
) (
    input  logic [N-1:0][W-1:0]       line_i,
    output logic [N-1:0][W-1:0]       line_o,
    output logic [W+$clog2(N*N)-1:0]  score_o,
    output logic                      changed_o,
    output logic                      win_o
);
    localparam int SW = W + $clog2(N*N);

    // Extra zero slot at index N lets the pair test read comp[i+1] for every i.
    logic [N:0][W-1:0]   comp;
    logic [N-1:0][W-1:0] res;
    logic [W-1:0]        dbl;
    logic [SW-1:0]       sc;
    logic                hit;
    logic                skip;

    // Compact, then a single merge pass that writes its output already compacted.
    always_comb begin : p_merge
        int k;
        comp = '0;
        res  = '0;
        dbl  = '0;
        sc   = '0;
        hit  = 1'b0;
        skip = 1'b0;
        k    = 0;
        for (int i = 0; i < N; i++) begin
            if (line_i[i] != '0) begin
                for (int j = 0; j < N; j++) begin
                    if (j == k) comp[j] = line_i[i];
                end
                k = k + 1;
            end
        end
        k = 0;
        for (int i = 0; i < N; i++) begin
            if (skip) begin
                // Partner of the previous merge: already consumed.
                skip = 1'b0;
            end else if (comp[i] != '0 && comp[i] == comp[i+1] && !comp[i][W-1]) begin
                // MSB-set pairs are left alone so the doubled value cannot overflow.
                dbl = {comp[i][W-2:0], 1'b0};
                for (int j = 0; j < N; j++) begin
                    if (j == k) res[j] = dbl;
                end
                sc   = sc + SW'(dbl);
                if (dbl == W'(WIN_VALUE)) hit = 1'b1;
                k    = k + 1;
                skip = 1'b1;
            end else if (comp[i] != '0) begin
                for (int j = 0; j < N; j++) begin
                    if (j == k) res[j] = comp[i];
                end
                k = k + 1;
            end
        end
    end

    assign line_o    = res;
    assign score_o   = sc;
    assign changed_o = (res != line_i);
    assign win_o     = hit;

endmodule

// File: rtl/tile_merge_engine.sv
// Tile merge engine: snapshots a board on start, processes one line per
// cycle through line_merge, and pulses done with the moved board.
module tile_merge_engine
    import game_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int W         = DEF_W,
    parameter int WIN_VALUE = 2048
) (
    input  logic               clk,
    input  logic               rst,
    tile_merge_engine_if.slave bus
);
    localparam int SW = W + $clog2(N*N);
    localparam int LW = $clog2(N);

    typedef logic [N-1:0][N-1:0][W-1:0] board_t;

    state_e              state_q, state_d;
    logic [LW-1:0]       line_q, line_d;
    logic [3:0]          dir_q, dir_d;
    board_t              board_q, board_d;
    logic [SW-1:0]       score_q, score_d;
    logic                moved_q, moved_d;
    logic                win_q, win_d;

    logic [N-1:0][W-1:0] line_rd;
    logic [N-1:0][W-1:0] line_wr;
    logic [SW-1:0]       line_score;
    logic                line_changed;
    logic                line_win;
    logic                dir_ok;

    assign dir_ok = dir_valid(dir_q);

    // Gather the current line so that element 0 is the edge tiles slide toward.
    always_comb begin
        line_rd = '0;
        for (int e = 0; e < N; e++) begin
            case (dir_q)
                DIR_DOWN:  line_rd[e] = board_q[e][line_q];
                DIR_UP:    line_rd[e] = board_q[N-1-e][line_q];
                DIR_LEFT:  line_rd[e] = board_q[line_q][e];
                DIR_RIGHT: line_rd[e] = board_q[line_q][N-1-e];
                default:   line_rd[e] = '0;
            endcase
        end
    end

    line_merge #(
        .N         (N),
        .W         (W),
        .WIN_VALUE (WIN_VALUE)
    ) u_line_merge (
        .line_i    (line_rd),
        .line_o    (line_wr),
        .score_o   (line_score),
        .changed_o (line_changed),
        .win_o     (line_win)
    );

    // Next-state logic: accept a move in IDLE, scatter one line per PROC cycle.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        dir_d   = dir_q;
        board_d = board_q;
        score_d = score_q;
        moved_d = moved_q;
        win_d   = win_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_PROC;
                    line_d  = '0;
                    dir_d   = bus.direction;
                    board_d = bus.matrix;
                    score_d = '0;
                    moved_d = 1'b0;
                    win_d   = 1'b0;
                end
            end
            ST_PROC: begin
                // An illegal direction leaves the snapshot untouched but keeps normal timing.
                if (dir_ok) begin
                    for (int e = 0; e < N; e++) begin
                        case (dir_q)
                            DIR_DOWN:  board_d[e][line_q]     = line_wr[e];
                            DIR_UP:    board_d[N-1-e][line_q] = line_wr[e];
                            DIR_LEFT:  board_d[line_q][e]     = line_wr[e];
                            DIR_RIGHT: board_d[line_q][N-1-e] = line_wr[e];
                            default:   ;
                        endcase
                    end
                    score_d = score_q + line_score;
                    moved_d = moved_q | line_changed;
                    win_d   = win_q | line_win;
                end
                if (line_q == LW'(N-1)) begin
                    state_d = ST_DONE;
                end else begin
                    line_d = line_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset clears control and the visible result alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            dir_q   <= '0;
            board_q <= '0;
            score_q <= '0;
            moved_q <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            dir_q   <= dir_d;
            board_q <= board_d;
            score_q <= score_d;
            moved_q <= moved_d;
            win_q   <= win_d;
        end
    end

    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.done          = (state_q == ST_DONE);
    assign bus.summed_matrix = board_q;
    assign bus.score         = score_q;
    assign bus.moved         = moved_q;
    assign bus.win           = win_q;

endmodule

// File: tb/tb_tile_merge_engine.sv
// Directed bench for tile_merge_engine: a table of hand-computed moves plus
// sequences for reset-during-move, start-while-busy and start-with-reset.
module tb_tile_merge_engine;
    import game_pkg::*;

    localparam int N  = 4;
    localparam int W  = 12;
    localparam int NV = 10;

    typedef logic [N-1:0][W-1:0]        row_t;
    typedef logic [N-1:0][N-1:0][W-1:0] board_t;

    typedef struct {
        string      name;
        logic [3:0] dir;
        board_t     m;
        board_t     exp;
        int         score;
        logic       moved;
        logic       win;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    tile_merge_engine_if #(.N(N), .W(W)) bus ();

    tile_merge_engine #(.N(N), .W(W), .WIN_VALUE(2048)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[NV];
    int   nv = 0;

    // Row helper: arguments are columns 0..3 left to right.
    function automatic row_t row4(input int c0, input int c1, input int c2, input int c3);
        row_t r;
        r[0] = W'(c0);
        r[1] = W'(c1);
        r[2] = W'(c2);
        r[3] = W'(c3);
        return r;
    endfunction

    // Board helper: arguments are rows 0 (bottom) to 3 (top).
    function automatic board_t brd(input row_t r0, input row_t r1, input row_t r2, input row_t r3);
        board_t b;
        b[0] = r0;
        b[1] = r1;
        b[2] = r2;
        b[3] = r3;
        return b;
    endfunction

    task automatic add(input string nm, input logic [3:0] d, input board_t m, input board_t e,
                       input int sc, input logic mv, input logic wn);
        vecs[nv].name  = nm;
        vecs[nv].dir   = d;
        vecs[nv].m     = m;
        vecs[nv].exp   = e;
        vecs[nv].score = sc;
        vecs[nv].moved = mv;
        vecs[nv].win   = wn;
        nv++;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one move; returns the cycle index (start = cycle 0) at which done is seen.
    task automatic run_move(input string nm, input logic [3:0] d, input board_t m, output int lat);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.direction = d;
        bus.matrix    = m;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.direction = 4'b0000;
        bus.matrix    = '0;
        lat = 1;
        chk({nm, "_busy_c1"}, bus.busy, 1);
        while (bus.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int     lat;
        int     dcnt;
        int     first;
        board_t cap;

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.direction = 4'b0000;
        bus.matrix    = '0;

        add("down4", DIR_DOWN,
            brd(row4(2,0,0,0), row4(2,0,0,0), row4(2,0,0,0), row4(2,0,0,0)),
            brd(row4(4,0,0,0), row4(4,0,0,0), '0, '0), 8, 1'b1, 1'b0);
        add("left_nochain", DIR_LEFT,
            brd(row4(2,0,2,4), '0, '0, '0),
            brd(row4(4,4,0,0), '0, '0, '0), 4, 1'b1, 1'b0);
        add("right_packed", DIR_RIGHT,
            brd(row4(0,2,4,8), row4(0,0,16,32), row4(0,0,0,2), row4(4,8,16,32)),
            brd(row4(0,2,4,8), row4(0,0,16,32), row4(0,0,0,2), row4(4,8,16,32)), 0, 1'b0, 1'b0);
        add("up_win", DIR_UP,
            brd(row4(0,0,0,2), '0, row4(0,1024,2048,0), row4(0,1024,2048,0)),
            brd('0, '0, row4(0,0,2048,0), row4(0,2048,2048,2)), 2048, 1'b1, 1'b1);
        add("dir0011", 4'b0011,
            brd(row4(2,2,0,0), row4(2,0,0,0), '0, '0),
            brd(row4(2,2,0,0), row4(2,0,0,0), '0, '0), 0, 1'b0, 1'b0);
        add("dir0000", 4'b0000,
            brd(row4(2,2,0,0), row4(2,0,0,0), '0, '0),
            brd(row4(2,2,0,0), row4(2,0,0,0), '0, '0), 0, 1'b0, 1'b0);
        add("right_merge", DIR_RIGHT,
            brd(row4(2,2,4,4), row4(2,2,2,0), '0, '0),
            brd(row4(0,0,4,8), row4(0,0,2,4), '0, '0), 16, 1'b1, 1'b0);
        add("down_three", DIR_DOWN,
            brd(row4(0,0,4,8), row4(0,0,4,0), row4(0,0,4,8), row4(0,0,0,16)),
            brd(row4(0,0,8,16), row4(0,0,4,16), '0, '0), 24, 1'b1, 1'b0);
        add("left_double_win", DIR_LEFT,
            brd('0, '0, row4(1024,1024,1024,1024), '0),
            brd('0, '0, row4(2048,2048,0,0), '0), 4096, 1'b1, 1'b1);
        add("left_msb", DIR_LEFT,
            brd(row4(2048,2048,0,0), row4(0,2048,0,2048), '0, '0),
            brd(row4(2048,2048,0,0), row4(2048,2048,0,0), '0, '0), 0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        chk("rst_busy",   bus.busy, 0);
        chk("rst_done",   bus.done, 0);
        chk("rst_score",  bus.score, 0);
        chk("rst_moved",  bus.moved, 0);
        chk("rst_win",    bus.win, 0);
        chk("rst_matrix", bus.summed_matrix, 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_move(vecs[i].name, vecs[i].dir, vecs[i].m, lat);
            chk({vecs[i].name, "_latency"}, lat, N + 1);
            chk({vecs[i].name, "_busy_done"}, bus.busy, 1);
            chk({vecs[i].name, "_matrix"}, bus.summed_matrix, vecs[i].exp);
            chk({vecs[i].name, "_score"}, bus.score, vecs[i].score);
            chk({vecs[i].name, "_moved"}, bus.moved, vecs[i].moved);
            chk({vecs[i].name, "_win"}, bus.win, vecs[i].win);
            @(negedge clk);
            chk({vecs[i].name, "_done_once"}, bus.done, 0);
            chk({vecs[i].name, "_idle"}, bus.busy, 0);
            chk({vecs[i].name, "_hold"}, bus.summed_matrix, vecs[i].exp);
            chk({vecs[i].name, "_hold_score"}, bus.score, vecs[i].score);
        end

        // Reset in cycle 2 of a move: aborted, cleared, and no done afterwards.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.direction = vecs[6].dir;
        bus.matrix    = vecs[6].m;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",   bus.busy, 0);
        chk("abort_done",   bus.done, 0);
        chk("abort_score",  bus.score, 0);
        chk("abort_moved",  bus.moved, 0);
        chk("abort_win",    bus.win, 0);
        chk("abort_matrix", bus.summed_matrix, 0);
        dcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        run_move("after_abort", vecs[1].dir, vecs[1].m, lat);
        chk("after_abort_latency", lat, N + 1);
        chk("after_abort_matrix", bus.summed_matrix, vecs[1].exp);
        chk("after_abort_score", bus.score, vecs[1].score);

        // Start pulses and input changes while busy must not disturb the move.
        @(negedge clk);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.direction = vecs[0].dir;
        bus.matrix    = vecs[0].m;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.direction = DIR_RIGHT;
        bus.matrix    = vecs[6].m;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dcnt  = 0;
        first = -1;
        cap   = '0;
        for (int c = 3; c < 15; c++) begin
            if (bus.done === 1'b1) begin
                dcnt++;
                if (first < 0) begin
                    first = c;
                    cap   = bus.summed_matrix;
                end
            end
            @(negedge clk);
        end
        chk("busy_start_done_count", dcnt, 1);
        chk("busy_start_done_cycle", first, N + 1);
        chk("busy_start_matrix", cap, vecs[0].exp);

        // Start together with reset: reset wins and nothing starts.
        @(negedge clk);
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.direction = vecs[0].dir;
        bus.matrix    = vecs[0].m;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_busy", bus.busy, 0);
        chk("rst_start_matrix", bus.summed_matrix, 0);
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcnt++;
        end
        chk("rst_start_no_done", dcnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
